// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcodes, ALUOp codes, datapath mux encodings and fault codes.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_RTYPE_EX,
        ST_RTYPE_WB,
        ST_BRANCH,
        ST_IMM_EX,
        ST_IMM_WB,
        ST_JUMP,
        ST_JAL,
        ST_FAULT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout
// once MAX_WAIT such cycles have already elapsed and memory is still not ready.
module mc_mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic              waiting;

    assign waiting   = active_i && !ready_i;
    assign timeout_o = waiting && (cnt_q == WAIT_W'(MAX_WAIT));

    // Every exit from a memory state happens on ready or timeout, so clearing
    // whenever we are not still waiting is the same as clearing on state change.
    always_comb begin
        cnt_d = '0;
        if (waiting && !timeout_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory wait/timeout handling and sticky faults.
// Optional PERF_CNT_EN adds retired-instruction and active-cycle counters.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [OP_W-1:0]    op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               branch_ne_o,
    output logic [1:0]         pc_source_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic               ext_zero_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               retire_o,
    output logic [1:0]         fault_o,
    output logic [31:0]        perf_instr_o,
    output logic [31:0]        perf_cycle_o
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] fault_q;
    logic [1:0] fault_d;
    logic       timeout;

    // The branch decision is resolved in the datapath from zero and branch_ne.
    logic       zero_unused;
    assign zero_unused = zero_i;

    mc_mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .active_i  (is_mem_state(state_q)),
        .ready_i   (mem_ready_i),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fault_d         = fault_q;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_source_o     = PCSRC_ALU;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        ext_zero_o      = 1'b0;
        alu_op_o        = ALUOP_W'(ALU_ADD);
        reg_write_o     = 1'b0;
        reg_dst_o       = DST_RT;
        mem_to_reg_o    = M2R_ALUOUT;
        retire_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
                case (op_i)
                    OP_W'(OP_RTYPE): state_d = ST_RTYPE_EX;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):    state_d = ST_MEM_ADR;
                    OP_W'(OP_BEQ),
                    OP_W'(OP_BNE):   state_d = ST_BRANCH;
                    OP_W'(OP_ADDI),
                    OP_W'(OP_ANDI),
                    OP_W'(OP_ORI),
                    OP_W'(OP_SLTI):  state_d = ST_IMM_EX;
                    OP_W'(OP_J):     state_d = ST_JUMP;
                    OP_W'(OP_JAL):   state_d = ST_JAL;
                    default: begin
                        state_d = ST_FAULT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_d     = (op_i == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_MEM_WB;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = DST_RT;
                mem_to_reg_o = M2R_MDR;
                retire_o     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_RTYPE_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_B;
                alu_op_o    = ALUOP_W'(ALU_FUNCT);
                state_d     = ST_RTYPE_WB;
            end
            ST_RTYPE_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = DST_RD;
                mem_to_reg_o = M2R_ALUOUT;
                retire_o     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_B;
                alu_op_o        = ALUOP_W'(ALU_SUB);
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                branch_ne_o     = (op_i == OP_W'(OP_BNE));
                retire_o        = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_IMM_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                case (op_i)
                    OP_W'(OP_ANDI): begin
                        alu_op_o   = ALUOP_W'(ALU_AND);
                        ext_zero_o = 1'b1;
                    end
                    OP_W'(OP_ORI): begin
                        alu_op_o   = ALUOP_W'(ALU_OR);
                        ext_zero_o = 1'b1;
                    end
                    OP_W'(OP_SLTI): alu_op_o = ALUOP_W'(ALU_SLT);
                    default:        alu_op_o = ALUOP_W'(ALU_ADD);
                endcase
                state_d = ST_IMM_WB;
            end
            ST_IMM_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = DST_RT;
                mem_to_reg_o = M2R_ALUOUT;
                retire_o     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
                retire_o    = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_JAL: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCSRC_JUMP;
                reg_write_o  = 1'b1;
                reg_dst_o    = DST_RA;
                mem_to_reg_o = M2R_PC;
                retire_o     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fault_o = fault_q;

`ifdef PERF_CNT_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_cycle_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            perf_instr_q <= '0;
            perf_cycle_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
                perf_cycle_q <= perf_cycle_q + 32'd1;
            end
            if (retire_o) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
        end
    end

    assign perf_instr_o = perf_instr_q;
    assign perf_cycle_o = perf_cycle_q;
`else
    assign perf_instr_o = '0;
    assign perf_cycle_o = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a stimulus process queues expected
// control words per cycle, a monitor pops and compares them at the falling edge.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  op = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg, fault;
    logic        alu_src_a, ext_zero, reg_write, retire;
    logic [2:0]  alu_op;
    logic [31:0] perf_instr, perf_cycle;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .op_i            (op),
        .zero_i          (zero),
        .mem_ready_i     (mem_ready),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_ne_o     (branch_ne),
        .pc_source_o     (pc_source),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .ext_zero_o      (ext_zero),
        .alu_op_o        (alu_op),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .retire_o        (retire),
        .fault_o         (fault),
        .perf_instr_o    (perf_instr),
        .perf_cycle_o    (perf_cycle)
    );

    typedef struct {
        string       name;
        logic [23:0] ctl;
        logic [31:0] pins;
        logic [31:0] pcyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc_m  = 0;
    int unsigned ins_m  = 0;

    logic [23:0] got;
    assign got = {iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond, branch_ne,
                  pc_source, alu_src_a, alu_src_b, ext_zero, alu_op,
                  reg_write, reg_dst, mem_to_reg, retire, fault};

    function automatic logic [23:0] mk(
        input logic iord_e, input logic mr, input logic mw, input logic irw,
        input logic pcw, input logic pcc, input logic bne, input logic [1:0] pcs,
        input logic asa, input logic [1:0] asb, input logic ez, input logic [2:0] alu,
        input logic rw, input logic [1:0] rd, input logic [1:0] mtr, input logic ret,
        input logic [1:0] flt);
        return {iord_e, mr, mw, irw, pcw, pcc, bne, pcs, asa, asb, ez, alu, rw, rd, mtr, ret, flt};
    endfunction

    function automatic logic [23:0] e_fetch(input logic r);
        return mk(0, 1, 0, r, r, 0, 0, 2'b00, 0, 2'b01, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_decode();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_mem_adr();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_mem_rd();
        return mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_mem_wb();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 2'b00, 2'b01, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_mem_wr(input logic r);
        return mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, r, 2'b00);
    endfunction
    function automatic logic [23:0] e_rtype_ex();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 3'b010, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_rtype_wb();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 2'b01, 2'b00, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_branch(input logic ne);
        return mk(0, 0, 0, 0, 0, 1, ne, 2'b01, 1, 2'b00, 0, 3'b001, 0, 2'b00, 2'b00, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_imm_ex(input logic [2:0] alu, input logic ez);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, ez, alu, 0, 2'b00, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [23:0] e_imm_wb();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 2'b00, 2'b00, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_jump();
        return mk(0, 0, 0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_jal();
        return mk(0, 0, 0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 3'b000, 1, 2'b10, 2'b10, 1, 2'b00);
    endfunction
    function automatic logic [23:0] e_fault(input logic [1:0] code);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, code);
    endfunction

    // One clock cycle of stimulus. Only IDLE and FAULT have every control bit
    // (excluding the fault code) at zero, so that decides whether the cycle counts.
    task automatic step(input string nm, input logic [5:0] o, input logic rdy,
                        input logic z, input logic rn, input logic [23:0] e);
        exp_t x;
        reset_n   = rn;
        op        = o;
        mem_ready = rdy;
        zero      = z;
        if (!rn) begin
            cyc_m = 0;
            ins_m = 0;
        end
        x.name = nm;
        x.ctl  = e;
`ifdef PERF_CNT_EN
        x.pins = ins_m;
        x.pcyc = cyc_m;
`else
        x.pins = 32'd0;
        x.pcyc = 32'd0;
`endif
        sb.push_back(x);
        if (rn && (|e[23:3])) cyc_m++;
        if (rn && e[2]) ins_m++;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks += 2;
                if (got !== x.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got=%06h required=%06h", x.name, got, x.ctl);
                end else if ((perf_instr !== x.pins) || (perf_cycle !== x.pcyc)) begin
                    errors++;
                    $display("FAIL %s perf: got instr=%0d cycle=%0d required instr=%0d cycle=%0d",
                             x.name, perf_instr, perf_cycle, x.pins, x.pcyc);
                end else begin
                    $display("ok   %s ctl=%06h instr=%0d cycle=%0d",
                             x.name, got, perf_instr, perf_cycle);
                end
            end
        end
    end

    initial begin : stimulus
        @(posedge clk);
        #1;
        // Reset held for 3 cycles, then one IDLE cycle.
        for (int i = 0; i < 3; i++) step("reset", 6'h00, 1, 0, 0, 24'h0);
        step("idle", 6'h00, 1, 0, 1, 24'h0);

        // R-type with zero wait: retire on the 4th cycle.
        step("rt_fetch",  6'h00, 1, 0, 1, e_fetch(1));
        step("rt_decode", 6'h00, 1, 0, 1, e_decode());
        step("rt_ex",     6'h00, 1, 0, 1, e_rtype_ex());
        step("rt_wb",     6'h00, 1, 0, 1, e_rtype_wb());

        // lw with three wait cycles in MEM_RD (8 cycles total).
        step("lw_fetch",  6'h23, 1, 0, 1, e_fetch(1));
        step("lw_decode", 6'h23, 1, 0, 1, e_decode());
        step("lw_adr",    6'h23, 1, 0, 1, e_mem_adr());
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 6'h23, 0, 0, 1, e_mem_rd());
        step("lw_rd_done", 6'h23, 1, 0, 1, e_mem_rd());
        step("lw_wb",      6'h23, 1, 0, 1, e_mem_wb());

        // sw with one wait cycle in MEM_WR.
        step("sw_fetch",   6'h2B, 1, 0, 1, e_fetch(1));
        step("sw_decode",  6'h2B, 1, 0, 1, e_decode());
        step("sw_adr",     6'h2B, 1, 0, 1, e_mem_adr());
        step("sw_wr_wait", 6'h2B, 0, 0, 1, e_mem_wr(0));
        step("sw_wr_done", 6'h2B, 1, 0, 1, e_mem_wr(1));

        // bne then beq.
        step("bne_fetch",  6'h05, 1, 0, 1, e_fetch(1));
        step("bne_decode", 6'h05, 1, 0, 1, e_decode());
        step("bne_branch", 6'h05, 1, 0, 1, e_branch(1));
        step("beq_fetch",  6'h04, 1, 0, 1, e_fetch(1));
        step("beq_decode", 6'h04, 1, 0, 1, e_decode());
        step("beq_branch", 6'h04, 1, 0, 1, e_branch(0));

        // Immediates: andi (zero-extend) and slti.
        step("andi_fetch",  6'h0C, 1, 0, 1, e_fetch(1));
        step("andi_decode", 6'h0C, 1, 0, 1, e_decode());
        step("andi_ex",     6'h0C, 1, 0, 1, e_imm_ex(3'b011, 1));
        step("andi_wb",     6'h0C, 1, 0, 1, e_imm_wb());
        step("slti_fetch",  6'h0A, 1, 0, 1, e_fetch(1));
        step("slti_decode", 6'h0A, 1, 0, 1, e_decode());
        step("slti_ex",     6'h0A, 1, 0, 1, e_imm_ex(3'b101, 0));
        step("slti_wb",     6'h0A, 1, 0, 1, e_imm_wb());

        // jal then j.
        step("jal_fetch",  6'h03, 1, 0, 1, e_fetch(1));
        step("jal_decode", 6'h03, 1, 0, 1, e_decode());
        step("jal_exec",   6'h03, 1, 0, 1, e_jal());
        step("j_fetch",    6'h02, 1, 0, 1, e_fetch(1));
        step("j_decode",   6'h02, 1, 0, 1, e_decode());
        step("j_exec",     6'h02, 1, 0, 1, e_jump());

        // Fetch timeout: 16 not-ready cycles, then sticky FAULT 10.
        for (int i = 0; i < 16; i++) step("to_fetch_wait", 6'h00, 0, 0, 1, e_fetch(0));
        step("to_fault", 6'h00, 0, 0, 1, e_fault(2'b10));
        step("to_fault_hold", 6'h00, 1, 0, 1, e_fault(2'b10));
        step("to_reset", 6'h00, 1, 0, 0, 24'h0);
        step("to_idle",  6'h00, 1, 0, 1, 24'h0);

        // Ready arriving on the 16th wait cycle wins over the timeout.
        for (int i = 0; i < 15; i++) step("edge_fetch_wait", 6'h02, 0, 0, 1, e_fetch(0));
        step("edge_fetch_ready", 6'h02, 1, 0, 1, e_fetch(1));
        step("edge_decode",      6'h02, 1, 0, 1, e_decode());
        step("edge_jump",        6'h02, 1, 0, 1, e_jump());

        // Illegal opcode, then reset from inside FAULT.
        step("ill_fetch",  6'h3F, 1, 0, 1, e_fetch(1));
        step("ill_decode", 6'h3F, 1, 0, 1, e_decode());
        step("ill_fault",  6'h3F, 1, 0, 1, e_fault(2'b01));
        step("ill_hold",   6'h3F, 0, 0, 1, e_fault(2'b01));
        step("ill_reset",  6'h3F, 1, 0, 0, 24'h0);
        step("ill_idle",   6'h00, 1, 0, 1, 24'h0);
        step("ill_refetch", 6'h00, 1, 0, 1, e_fetch(1));

        // Abort mid-instruction: reset during RTYPE_EX gives no retire.
        step("abort_decode", 6'h00, 1, 0, 1, e_decode());
        step("abort_reset",  6'h00, 1, 0, 0, 24'h0);
        step("abort_idle",   6'h00, 1, 0, 1, 24'h0);
        step("abort_fetch",  6'h00, 0, 0, 1, e_fetch(0));

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
